// File: rtl/tower_game_fsm.sv
// tower_game_fsm: block-stacking game sequencer with key edge detection, pause and win/lose tracking
module tower_game_fsm #(
    parameter int MAX_ROWS     = 16,
    parameter int INIT_CHANCES = 3,
    parameter int LEVEL_STEP   = 4,
    parameter int MAX_LEVEL    = 7,
    parameter int SCORE_W      = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             place_key,
    input  logic                             pause_key,
    input  logic                             overlap,
    output logic                             ld_x,
    output logic                             ld_y,
    output logic                             ld_d,
    output logic                             ld_df,
    output logic                             enable,
    output logic                             save_x,
    output logic                             inc_row,
    output logic [$clog2(MAX_ROWS+1)-1:0]    row,
    output logic [$clog2(INIT_CHANCES+1)-1:0] chances,
    output logic [SCORE_W-1:0]               score,
    output logic [$clog2(MAX_LEVEL+1)-1:0]   level,
    output logic [1:0]                       game_status
);
    localparam int RW = $clog2(MAX_ROWS+1);
    localparam int CW = $clog2(INIT_CHANCES+1);
    localparam int LW = $clog2(MAX_LEVEL+1);

    typedef enum logic [2:0] {LOAD, MOVE, PAUSE, JUDGE, SUCCESS, FAIL, WIN, LOSE} state_t;

    state_t state, state_n;
    logic place_q, pause_q, place_p, pause_p;
    logic [RW-1:0] row_n;

    assign place_p = place_key & ~place_q;
    assign pause_p = pause_key & ~pause_q;
    assign row_n   = row + RW'(1);

    // State, key history and game counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOAD;
            place_q <= 1'b0;
            pause_q <= 1'b0;
            row     <= '0;
            score   <= '0;
            level   <= '0;
            chances <= CW'(INIT_CHANCES);
        end else begin
            state   <= state_n;
            place_q <= place_key;
            pause_q <= pause_key;
            if (state == SUCCESS) begin
                row   <= row_n;
                score <= (score == '1) ? score : score + SCORE_W'(1);
                if ((32'(row_n) % LEVEL_STEP) == 0 && level != LW'(MAX_LEVEL))
                    level <= level + LW'(1);
            end
            if (state == FAIL && chances != '0)
                chances <= chances - CW'(1);
        end
    end

    // Next state and Moore strobes
    always_comb begin
        state_n     = state;
        ld_x        = 1'b0;
        ld_y        = 1'b0;
        ld_d        = 1'b0;
        ld_df       = 1'b0;
        enable      = 1'b0;
        save_x      = 1'b0;
        inc_row     = 1'b0;
        game_status = 2'b01;
        case (state)
            LOAD: begin
                {ld_x, ld_y, ld_d, ld_df} = 4'b1111;
                state_n = MOVE;
            end
            MOVE: begin
                enable  = 1'b1;
                state_n = pause_p ? PAUSE : !place_p ? MOVE : (row == '0) ? SUCCESS : JUDGE;
            end
            PAUSE: begin
                game_status = 2'b00;
                state_n     = pause_p ? MOVE : PAUSE;
            end
            JUDGE: state_n = overlap ? SUCCESS : FAIL;
            SUCCESS: begin
                save_x  = 1'b1;
                inc_row = 1'b1;
                state_n = (row_n == RW'(MAX_ROWS)) ? WIN : LOAD;
            end
            FAIL: begin
                {ld_x, ld_y, ld_d} = 3'b111;
                state_n = (chances == CW'(1)) ? LOSE : MOVE;
            end
            WIN:  game_status = 2'b11;
            LOSE: game_status = 2'b10;
            default: begin
                game_status = 2'b10;
                state_n     = LOAD;
            end
        endcase
    end
endmodule

// File: tb/tb_tower_game_fsm.sv
// tb_tower_game_fsm: directed and random checks of tower_game_fsm against a behavioural game model
module tb_tower_game_fsm;
    localparam int MR = 4;
    localparam int IC = 3;
    localparam int LS = 2;
    localparam int ML = 7;
    localparam int SW = 8;

    localparam int G_LOAD = 0, G_MOVE = 1, G_PAUSE = 2, G_JUDGE = 3,
                   G_SUCC = 4, G_FAIL = 5, G_WIN = 6, G_LOSE = 7;

    logic clk = 1'b0;
    logic reset = 1'b0, place_key = 1'b0, pause_key = 1'b0, overlap = 1'b0;
    logic ld_x, ld_y, ld_d, ld_df, enable, save_x, inc_row;
    logic [$clog2(MR+1)-1:0] row;
    logic [$clog2(IC+1)-1:0] chances;
    logic [SW-1:0] score;
    logic [$clog2(ML+1)-1:0] level;
    logic [1:0] game_status;

    int errs = 0;
    int checks = 0;

    int g_ph, g_row, g_ch;
    logic g_pq, g_sq;

    tower_game_fsm #(.MAX_ROWS(MR), .INIT_CHANCES(IC), .LEVEL_STEP(LS), .MAX_LEVEL(ML), .SCORE_W(SW)) dut (
        .clk(clk), .reset(reset), .place_key(place_key), .pause_key(pause_key), .overlap(overlap),
        .ld_x(ld_x), .ld_y(ld_y), .ld_d(ld_d), .ld_df(ld_df), .enable(enable), .save_x(save_x),
        .inc_row(inc_row), .row(row), .chances(chances), .score(score), .level(level),
        .game_status(game_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Strobe/status pattern {ld_x,ld_y,ld_d,ld_df,enable,save_x,inc_row,status} per game phase
    function automatic logic [8:0] phase_out(input int ph);
        case (ph)
            G_LOAD:  return 9'b1111_000_01;
            G_MOVE:  return 9'b0000_100_01;
            G_PAUSE: return 9'b0000_000_00;
            G_JUDGE: return 9'b0000_000_01;
            G_SUCC:  return 9'b0000_011_01;
            G_FAIL:  return 9'b1110_000_01;
            G_WIN:   return 9'b0000_000_11;
            default: return 9'b0000_000_10;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic pk, input logic sk, input logic ov);
        logic pp, sp;
        if (rst) begin
            g_ph = G_LOAD; g_row = 0; g_ch = IC; g_pq = 1'b0; g_sq = 1'b0;
            return;
        end
        pp = pk & ~g_pq;
        sp = sk & ~g_sq;
        g_pq = pk;
        g_sq = sk;
        case (g_ph)
            G_LOAD:  g_ph = G_MOVE;
            G_MOVE:  if (sp) g_ph = G_PAUSE; else if (pp) g_ph = (g_row == 0) ? G_SUCC : G_JUDGE;
            G_PAUSE: if (sp) g_ph = G_MOVE;
            G_JUDGE: g_ph = ov ? G_SUCC : G_FAIL;
            G_SUCC: begin
                g_row++;
                g_ph = (g_row == MR) ? G_WIN : G_LOAD;
            end
            G_FAIL: begin
                g_ch--;
                g_ph = (g_ch == 0) ? G_LOSE : G_MOVE;
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        logic [8:0] e;
        int exp_lvl, exp_sc;
        e = phase_out(g_ph);
        exp_lvl = (g_row / LS > ML) ? ML : g_row / LS;
        exp_sc  = (g_row > (1 << SW) - 1) ? (1 << SW) - 1 : g_row;
        chk("strobes", {ld_x, ld_y, ld_d, ld_df, enable, save_x, inc_row, game_status}, e);
        chk("row", row, g_row);
        chk("chances", chances, g_ch);
        chk("score", score, exp_sc);
        chk("level", level, exp_lvl);
    endtask

    task automatic step(input logic rst, input logic pk, input logic sk, input logic ov);
        reset = rst; place_key = pk; pause_key = sk; overlap = ov;
        @(posedge clk);
        model_edge(rst, pk, sk, ov);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input logic ov);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, ov);
    endtask

    initial begin
        int judges;
        logic pk, sk;
        int term;

        // Reset and LOAD -> MOVE
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_ld", {ld_x, ld_y, ld_d, ld_df}, 4'b1111);
        chk("reset_status", game_status, 2'b01);
        idle(2, 1'b0);
        chk("move_enable", enable, 1'b1);
        chk("move_chances", chances, 3);

        // Row 0 is never judged
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("row0_inc", {save_x, inc_row}, 2'b11);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("row0_row", row, 1);
        chk("row0_score", score, 1);
        idle(1, 1'b0);

        // Three misses on row 1 end the game
        for (int k = 0; k < IC; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("fail_relaunch", {ld_x, ld_y, ld_d, ld_df}, 4'b1110);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk("fail_chances", chances, IC - 1 - k);
        end
        idle(20, 1'b0);
        chk("lose_status", game_status, 2'b10);

        // Perfect game to the win height
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        for (int k = 0; k < MR; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            idle(4, 1'b1);
        end
        chk("win_status", game_status, 2'b11);
        chk("win_row", row, MR);
        chk("win_score", score, MR);
        chk("win_level", level, 2);

        // Simultaneous pause and place: pause wins, place discarded
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("pause_status", game_status, 2'b00);
        chk("pause_enable", enable, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("resume_status", game_status, 2'b01);
        chk("resume_enable", enable, 1'b1);
        chk("resume_row", row, 0);

        // Held place key yields a single judgement, then reset during JUDGE
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(3, 1'b0);
        judges = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if ({ld_x, ld_y, ld_d, ld_df, enable, save_x, inc_row, game_status} == 9'b0000_000_01) judges++;
        end
        chk("held_judges", judges, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("judge_reset_row", row, 0);
        chk("judge_reset_ld", {ld_x, ld_y, ld_d, ld_df}, 4'b1111);

        // Random play
        pk = 1'b0; sk = 1'b0; term = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2) == 0) pk = ~pk;
            if ($urandom_range(0, 9) == 0) sk = ~sk;
            term = (g_ph == G_WIN || g_ph == G_LOSE) ? term + 1 : 0;
            step(($urandom_range(0, 299) == 0) || term > 8, pk, sk, 1'($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/tower_game_fsm.md
Name: tower_game_fsm

Overview:
- Parametrised successor to the single-tower gameplay controller. It sequences one game of block stacking and drives the gameplay datapath strobes.
- Unlike its predecessor, it owns the chance, row, score and difficulty-level counters internally. It edge-detects the place and pause keys, supports pause/resume, and declares a win at a configurable tower height.
- It sits between the key synchroniser and the gameplay datapath, and feeds game_status and counters to the display FSM.

Parameters:
- MAX_ROWS, 16, rows needed to win (>=2).
- INIT_CHANCES, 3, chances at game start (>=1).
- LEVEL_STEP, 4, successful rows per difficulty-level increment (>=1).
- MAX_LEVEL, 7, saturation value of level.
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  system clock, all logic posedge.
- reset  in  1  synchronous, active-high reset.
- place_key  in  1  synchronised place key, active-high level.
- pause_key  in  1  synchronised pause key, active-high level.
- overlap  in  1  datapath: current block overlaps the block below (valid in JUDGE).
- ld_x, ld_y, ld_d, ld_df  out  1 each  datapath parallel-load strobes.
- enable  out  1  allow block x shifting.
- save_x  out  1  latch current x as the previous-row x.
- inc_row  out  1  datapath row advance.
- row  out  $clog2(MAX_ROWS+1)  rows completed.
- chances  out  $clog2(INIT_CHANCES+1)  remaining chances.
- score  out  SCORE_W  score.
- level  out  $clog2(MAX_LEVEL+1)  difficulty level.
- game_status  out  2  00 paused, 01 playing, 10 lost, 11 won.

Behaviour:
- Reset (one clk with reset=1):
  - State LOAD; row=0; score=0; level=0; chances=INIT_CHANCES.
  - Edge-detector history registers cleared.
  - All strobes are combinational Moore outputs of the state. They equal LOAD outputs during and after reset until the state changes.
- Reset asserted mid-game overrides everything on the next edge, including WIN/LOSE.
- Key edges:
  - place_p = place_key & ~place_q; pause_p = pause_key & ~pause_q, where the _q registers hold the previous cycle's level.
  - Each is a one-cycle pulse per press; a held key produces no repeats.
- States and transitions (all transitions on posedge clk):
  - LOAD: ld_x=ld_y=ld_d=ld_df=1, status 01 -> MOVE.
  - MOVE: enable=1, status 01.
    - pause_p -> PAUSE. Pause has priority over a simultaneous place_p, and that place_p is discarded.
    - Else place_p with row==0 -> SUCCESS. The first row is never judged.
    - Else place_p -> JUDGE.
    - Else stay in MOVE.
  - PAUSE: no strobes, status 00. pause_p -> MOVE; place_p is ignored.
  - JUDGE: no strobes, status 01. overlap=1 -> SUCCESS; else -> FAIL.
  - SUCCESS: save_x=inc_row=1, status 01.
    - row+=1; score+=1, saturating at 2^SCORE_W-1.
    - If the new row is a multiple of LEVEL_STEP, level+=1, saturating at MAX_LEVEL.
    - Next state WIN if the new row==MAX_ROWS, else LOAD. Chances are unchanged on success.
  - FAIL: ld_x=ld_y=ld_d=1 (relaunch the same row; ld_df=0), status 01, chances-=1.
    - Next state LOSE if chances was 1 (now 0), else MOVE.
  - WIN: status 11, no strobes, counters frozen, terminal until reset.
  - LOSE: status 10, no strobes, counters frozen, terminal until reset.
  - Unreachable encodings -> LOAD with status 10.
- Latency:
  - Place press to inc_row: 1 cycle on row 0 (MOVE->SUCCESS); 2 cycles otherwise (MOVE->JUDGE->SUCCESS).
  - Fail press to relaunch: 2 cycles.
- Counters never wrap: chances stops at 0 (LOSE is entered), row stops at MAX_ROWS.
- Key edges arriving in LOAD, JUDGE, SUCCESS or FAIL are dropped. The history registers still update, so a key held across those states yields no later pulse.

Test Plan:
- Reset, then 2 idle cycles: status 01. The LOAD cycle shows ld_x/ld_y/ld_d/ld_df=1. Then enable=1, chances=3, row=0, score=0.
- Place pulse on row 0 with overlap=0: the next cycle has save_x=inc_row=1. Then row=1, score=1, no chance lost, then LOAD.
- On row 1, place with overlap=0 three times (INIT_CHANCES=3): chances goes 2, then 1, then 0. FAIL asserts ld_x/ld_y/ld_d=1 with ld_df=0 each time. After the third, status=10 and stays 10 for 20 cycles with strobes low.
- MAX_ROWS=4, LEVEL_STEP=2, overlap held 1, four place presses: level goes 0->1 at row 2 and 1->2 at row 4. Status=11 with row=4, score=4.
- In MOVE, pause_key and place_key rise in the same cycle: PAUSE entered, status 00, enable=0, no JUDGE. place_key toggled during pause has no effect. Second pause press gives status 01 and enable=1, with row unchanged.
- Hold place_key high 10 cycles: exactly one JUDGE. Assert reset while in JUDGE: the next cycle is LOAD with counters at reset values.
